// File: rtl/apb_pkg.sv
// apb_pkg: shared APB types and constants for the master arbiter.
//   ADDR_WIDTH / DATA_WIDTH   : APB bus widths
//   addr_t / data_t           : bus word types
//   apb_req_t                 : one requester's transfer (paddr, pwrite, pwdata)
//   apb_state_t               : APB master FSM states
//   APB_TIMEOUT_CYCLES        : default ACCESS-cycle limit before forced termination
package apb_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    addr_t paddr;
    logic  pwrite;
    data_t pwdata;
  } apb_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side handshake plus APB master bus.
//   req_valid/req/req_ready     : per-requester request channel
//   rsp_valid/rsp_prdata/rsp_pslverr : completion channel
//   psel/penable/pwrite/paddr/pwdata : APB master outputs
//   prdata/pready/pslverr       : APB slave responses
// modport master: arbiter view; modport slave: environment view.
interface apb_master_arbiter_if import apb_pkg::*; #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  apb_req_t [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  data_t                        rsp_prdata;
  logic                         rsp_pslverr;
  logic                         psel;
  logic                         penable;
  logic                         pwrite;
  addr_t                        paddr;
  data_t                        pwdata;
  data_t                        prdata;
  logic                         pready;
  logic                         pslverr;

  modport master (
    input  req_valid, req, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_prdata, rsp_pslverr,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_prdata, rsp_pslverr,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational round-robin picker.
//   req_i        : request vector
//   last_grant_i : index of the most recently accepted requester
//   grant_o      : one-hot winner (zero when no request)
//   grant_idx_o  : winner index
//   valid_o      : any request present
// Search starts at last_grant_i+1 and wraps, so last_grant_i itself is lowest priority.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      grant_idx_o,
  output logic               valid_o
);
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  assign valid_o = found;
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port among NUM_REQ requesters.
//   pclk    : clock (rising edge)
//   presetn : asynchronous active-low reset
//   bus     : requester handshake + APB master signals (master modport)
// Round-robin acceptance in IDLE or on ACCESS completion (back-to-back SETUP),
// wait-state counting with forced error termination after TIMEOUT ACCESS cycles.
module apb_master_arbiter import apb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = APB_TIMEOUT_CYCLES
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_master_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_t         state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  addr_t              paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  data_t              pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  data_t              rsp_prdata_q, rsp_prdata_d;
  logic               rsp_pslverr_q, rsp_pslverr_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               any_req;
  logic               in_access, accept, timeout;
  logic [NUM_REQ-1:0] owner_oh;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i        (bus.req_valid),
    .last_grant_i (last_q),
    .grant_o      (gnt),
    .grant_idx_o  (gnt_idx),
    .valid_o      (any_req)
  );

  assign in_access = (state_q == ACCESS);
  // A new request can be taken when the bus is free or the current transfer finishes now.
  assign accept    = any_req && ((state_q == IDLE) || (in_access && bus.pready));
  // pready in the last allowed cycle wins over the timeout.
  assign timeout   = in_access && !bus.pready && (wcnt_q == WW'(TIMEOUT-1));
  // last_q only moves on acceptance, so it always names the current owner.
  assign owner_oh  = NUM_REQ'(1) << last_q;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    wcnt_d        = wcnt_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = '0;
    rsp_prdata_d  = rsp_prdata_q;
    rsp_pslverr_d = rsp_pslverr_q;
    if (accept) begin
      paddr_d  = bus.req[gnt_idx].paddr;
      pwrite_d = bus.req[gnt_idx].pwrite;
      pwdata_d = bus.req[gnt_idx].pwdata;
      last_d   = gnt_idx;
    end
    case (state_q)
      IDLE:   if (any_req) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        wcnt_d  = '0;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d   = owner_oh;
          rsp_prdata_d  = bus.prdata;
          rsp_pslverr_d = bus.pslverr;
          state_d       = any_req ? SETUP : IDLE;
        end else if (timeout) begin
          rsp_valid_d   = owner_oh;
          rsp_prdata_d  = '0;
          rsp_pslverr_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      last_q        <= IW'(NUM_REQ-1);
      wcnt_q        <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= '0;
      rsp_prdata_q  <= '0;
      rsp_pslverr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      wcnt_q        <= wcnt_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_prdata_q  <= rsp_prdata_d;
      rsp_pslverr_q <= rsp_pslverr_d;
    end
  end

  assign bus.req_ready   = accept ? gnt : '0;
  assign bus.psel        = (state_q != IDLE);
  assign bus.penable     = in_access;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_prdata  = rsp_prdata_q;
  assign bus.rsp_pslverr = rsp_pslverr_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NUM_REQ=2, TIMEOUT=16) with a response scoreboard.
module tb_apb_master_arbiter;
  import apb_pkg::*;

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic  clk = 1'b0;
  logic  rstn;
  logic  echo = 1'b0;
  data_t prdata_drv = '0;
  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];
  exp_t  mon_e;

  always #5 clk = ~clk;

  apb_master_arbiter_if #(.NUM_REQ(2)) bus ();

  // Slave read data: either a fixed value or an address-derived tag.
  assign bus.prdata = echo ? (32'hC0DE0000 | bus.paddr) : prdata_drv;

  apb_master_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
    .pclk    (clk),
    .presetn (rstn),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic apb_req_t mk(input addr_t a, input logic w, input data_t d);
    apb_req_t r;
    r.paddr  = a;
    r.pwrite = w;
    r.pwdata = d;
    return r;
  endfunction

  task automatic push(input logic [1:0] oh, input logic [31:0] d, input logic e);
    exp_t x;
    x.oh = oh;
    x.d  = d;
    x.e  = e;
    sb.push_back(x);
  endtask

  // Response monitor: every rsp_valid pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rstn === 1'b1 && |bus.rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_owner", bus.rsp_valid, mon_e.oh);
        chk("rsp_prdata", bus.rsp_prdata, mon_e.d);
        chk("rsp_pslverr", bus.rsp_pslverr, mon_e.e);
      end
    end
  end

  initial begin
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.req[0] = '0;
    bus.req[1] = '0;
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    step();
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_prdata", bus.rsp_prdata, 0);
    chk("rst_rsp_pslverr", bus.rsp_pslverr, 0);
    step();
    rstn = 1'b1;

    // Contention: both requesters valid continuously, zero wait states.
    echo = 1'b1;
    bus.pready = 1'b1;
    bus.req[0] = mk(32'h010, 1'b0, '0);
    bus.req[1] = mk(32'h020, 1'b0, '0);
    bus.req_valid = 2'b11;
    #1;
    chk("cont_first_ready", bus.req_ready, 2'b01);
    push(2'b01, 32'hC0DE0010, 1'b0);
    push(2'b10, 32'hC0DE0020, 1'b0);
    push(2'b01, 32'hC0DE0010, 1'b0);
    push(2'b10, 32'hC0DE0020, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cont_setup_paddr", bus.paddr, (k % 2 == 0) ? 32'h010 : 32'h020);
      chk("cont_setup_psel", bus.psel, 1);
      chk("cont_setup_penable", bus.penable, 0);
      chk("cont_setup_ready", bus.req_ready, 0);
      if (k == 3) bus.req_valid = '0;
      step();
      chk("cont_access_penable", bus.penable, 1);
      chk("cont_access_ready", bus.req_ready, (k == 3) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01));
    end
    step();
    chk("cont_idle_psel", bus.psel, 0);
    echo = 1'b0;

    // Single write, zero wait states.
    bus.req[0] = mk(32'h004, 1'b1, 32'hDEADBEEF);
    bus.req_valid = 2'b01;
    prdata_drv = '0;
    #1;
    chk("wr_ready", bus.req_ready, 2'b01);
    push(2'b01, 32'h0, 1'b0);
    step();
    bus.req_valid = '0;
    chk("wr_setup_psel", bus.psel, 1);
    chk("wr_setup_penable", bus.penable, 0);
    chk("wr_paddr", bus.paddr, 32'h004);
    chk("wr_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("wr_pwrite", bus.pwrite, 1);
    step();
    chk("wr_access_psel", bus.psel, 1);
    chk("wr_access_penable", bus.penable, 1);
    step();
    chk("wr_done_psel", bus.psel, 0);
    chk("wr_rsp_valid", bus.rsp_valid, 2'b01);

    // Read with three wait states from requester 1.
    bus.pready = 1'b0;
    prdata_drv = 32'h12345678;
    bus.req[1] = mk(32'h100, 1'b0, '0);
    bus.req_valid = 2'b10;
    #1;
    chk("ws_ready", bus.req_ready, 2'b10);
    push(2'b10, 32'h12345678, 1'b0);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_penable", bus.penable, 1);
      chk("ws_paddr", bus.paddr, 32'h100);
      chk("ws_pwrite", bus.pwrite, 0);
      chk("ws_ready_low", bus.req_ready, 0);
    end
    bus.pready = 1'b1;
    step();
    bus.pready = 1'b0;
    chk("ws_done_psel", bus.psel, 0);
    chk("ws_rsp_prdata", bus.rsp_prdata, 32'h12345678);
    prdata_drv = '0;
    step();
    step();
    chk("ws_prdata_hold", bus.rsp_prdata, 32'h12345678);

    // Timeout: pready never arrives.
    prdata_drv = 32'hFFFFFFFF;
    bus.req[0] = mk(32'h200, 1'b0, '0);
    bus.req_valid = 2'b01;
    #1;
    push(2'b01, 32'h0, 1'b1);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("to_access_penable", bus.penable, 1);
    end
    step();
    chk("to_psel", bus.psel, 0);
    chk("to_penable", bus.penable, 0);
    chk("to_rsp_valid", bus.rsp_valid, 2'b01);
    chk("to_rsp_pslverr", bus.rsp_pslverr, 1);
    chk("to_rsp_prdata", bus.rsp_prdata, 0);

    // pready in the timeout cycle completes normally.
    prdata_drv = 32'hA5A5A5A5;
    bus.req[1] = mk(32'h204, 1'b0, '0);
    bus.req_valid = 2'b10;
    #1;
    push(2'b10, 32'hA5A5A5A5, 1'b0);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("prec_access_penable", bus.penable, 1);
      if (i == 15) bus.pready = 1'b1;
    end
    step();
    bus.pready = 1'b0;
    chk("prec_rsp_pslverr", bus.rsp_pslverr, 0);
    chk("prec_rsp_prdata", bus.rsp_prdata, 32'hA5A5A5A5);

    // Slave error on read of 0x3FF from requester 1.
    prdata_drv = 32'h0BAD0BAD;
    bus.req[1] = mk(32'h3FF, 1'b0, '0);
    bus.req_valid = 2'b10;
    bus.pready = 1'b1;
    bus.pslverr = 1'b1;
    #1;
    push(2'b10, 32'h0BAD0BAD, 1'b1);
    step();
    bus.req_valid = '0;
    step();
    step();
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    chk("err_rsp_valid", bus.rsp_valid, 2'b10);
    chk("err_rsp_pslverr", bus.rsp_pslverr, 1);

    // Reset in the middle of ACCESS.
    bus.req[1] = mk(32'h050, 1'b1, 32'h55AA55AA);
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = '0;
    step();
    step();
    chk("mid_penable", bus.penable, 1);
    rstn = 1'b0;
    #1;
    chk("mrst_psel", bus.psel, 0);
    chk("mrst_penable", bus.penable, 0);
    chk("mrst_pwrite", bus.pwrite, 0);
    chk("mrst_paddr", bus.paddr, 0);
    chk("mrst_pwdata", bus.pwdata, 0);
    chk("mrst_rsp_prdata", bus.rsp_prdata, 0);
    chk("mrst_rsp_pslverr", bus.rsp_pslverr, 0);
    step();
    step();
    rstn = 1'b1;
    bus.req[0] = mk(32'h060, 1'b1, 32'h11112222);
    bus.req[1] = mk(32'h070, 1'b1, 32'h33334444);
    bus.req_valid = 2'b11;
    prdata_drv = '0;
    bus.pready = 1'b1;
    #1;
    chk("post_rst_ready", bus.req_ready, 2'b01);
    push(2'b01, 32'h0, 1'b0);
    step();
    bus.req_valid = '0;
    chk("post_rst_psel", bus.psel, 1);
    chk("post_rst_paddr", bus.paddr, 32'h060);
    step();
    step();
    bus.pready = 1'b0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    chk("sb_drain", sb.size(), 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, is the number of requesters sharing the APB bus (2..4).
REQ-002 Parameter TIMEOUT, default 16, is the maximum number of ACCESS cycles waited for pready before forced termination.
REQ-003 pclk  input  1  is the single clock; all logic is rising-edge.
REQ-004 presetn  input  1  is the reset: asynchronous assertion, active-low.
REQ-005 req_valid  input  NUM_REQ  is the per-requester transfer request.
REQ-006 req  input  NUM_REQ x apb_req_t  is the per-requester paddr/pwrite/pwdata, held stable while req_valid is high.
REQ-007 req_ready  output  NUM_REQ  is one-hot acceptance; a request transfers when req_valid[i] && req_ready[i].
REQ-008 rsp_valid  output  NUM_REQ  is a one-cycle completion pulse to the owning requester.
REQ-009 rsp_prdata  output  DATA_WIDTH  is the read data, valid with any rsp_valid bit.
REQ-010 rsp_pslverr  output  1  is the error flag, valid with any rsp_valid bit.
REQ-011 psel, penable, pwrite  output  1 each  are the APB master controls.
REQ-012 paddr  output  ADDR_WIDTH, and pwdata  output  DATA_WIDTH, are the APB address and write data.
REQ-013 prdata  input  DATA_WIDTH, pready  input  1, and pslverr  input  1 are the APB slave responses.

Function
REQ-014 The FSM shall use apb_state_t: IDLE (psel=0, penable=0), SETUP (psel=1, penable=0), ACCESS (psel=1, penable=1).
REQ-015 In IDLE with any req_valid, the arbiter shall assert req_ready for exactly one winner combinationally, latch its req into paddr/pwrite/pwdata at the clock edge, and enter SETUP.
REQ-016 Arbitration shall be round-robin: priority starts at (last_grant+1) mod NUM_REQ; last_grant updates only on acceptance.
REQ-017 SETUP shall always go to ACCESS after exactly one cycle.
REQ-018 In ACCESS without pready, the FSM shall hold all APB outputs stable and increment the wait counter.
REQ-019 In ACCESS with pready, the block shall register prdata and pslverr to rsp_prdata/rsp_pslverr and pulse rsp_valid[grant] in the next cycle.
REQ-020 On ACCESS completion with any req_valid pending, the block shall accept the round-robin winner in the same cycle and go directly to SETUP; otherwise it shall go to IDLE.
REQ-021 The wait counter shall clear on entry to ACCESS. If it reaches TIMEOUT-1 with pready low, the block shall end the transfer: psel/penable to 0, rsp_valid[grant] pulse with rsp_pslverr=1 and rsp_prdata=0, next state IDLE.
REQ-022 A pready arriving in the timeout cycle shall take precedence, giving normal completion.
REQ-023 req_ready shall be 0 in SETUP, and in ACCESS while pready is low.
REQ-024 rsp_prdata shall hold its value between rsp_valid pulses.
REQ-025 Steady-state throughput shall be one transfer per 2 cycles with zero-wait-state slaves.

Reset
REQ-026 On presetn low, the block shall immediately force: state IDLE, psel/penable/pwrite 0, paddr/pwdata 0, rsp_valid 0, rsp_prdata 0, rsp_pslverr 0, wait counter 0, last_grant NUM_REQ-1 (so requester 0 has first priority).
REQ-027 A reset asserted mid-transfer shall abandon the transfer with no rsp_valid pulse and no completion after reset release.
REQ-028 The first acceptance shall be possible in the first clock edge after presetn deasserts.

Structure
REQ-029 apb_state_t, apb_req_t, addr_t, data_t, ADDR_WIDTH and DATA_WIDTH shall come from apb_pkg; the new constant APB_TIMEOUT_CYCLES=16 shall be added there and used as the TIMEOUT default.
REQ-030 Round-robin grant logic shall be a sub-module apb_rr_arbiter (req vector, last_grant in; one-hot grant and index out, purely combinational).
REQ-031 The FSM, request latch, wait counter and response registers shall reside in apb_master_arbiter.

Verification
REQ-032 Single write: req_valid[0], paddr=0x004, pwdata=0xDEADBEEF, pready tied 1 -> SETUP then ACCESS, psel high 2 cycles, rsp_valid[0] 1 cycle after ACCESS, rsp_pslverr=0.
REQ-033 Contention: both requesters valid continuously (addr 0x010 / 0x020) -> grants alternate 0,1,0,1 with no idle cycle between transfers.
REQ-034 Wait states: pready low 3 ACCESS cycles, prdata=0x12345678 -> APB outputs stable, rsp_prdata=0x12345678 after pready.
REQ-035 Timeout: pready held 0 -> transfer ends after 16 ACCESS cycles, rsp_pslverr=1, rsp_prdata=0, state IDLE.
REQ-036 Slave error: pready=1 with pslverr=1 on read of 0x3FF -> rsp_pslverr=1 to the owning requester only.
REQ-037 Reset mid-ACCESS: presetn low 2 cycles -> all outputs at reset values immediately, no rsp_valid after release, next grant to requester 0.
